// File: rtl/axi_slv_wsink_bresp.sv
// axi_slv_wsink_bresp: AXI3 write sink checking W bursts against queued AW and returning in-order B responses
module axi_slv_wsink_bresp #(
  parameter int AXI_ID_W     = 4,
  parameter int AXI_DATA_W   = 32,
  parameter int SLV_OSTD_NUM = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  in_awvalid,
  output logic                  out_awready,
  input  logic [AXI_ID_W-1:0]   in_awid,
  input  logic [3:0]            in_awlen,
  input  logic                  in_wvalid,
  output logic                  out_wready,
  input  logic [AXI_ID_W-1:0]   in_wid,
  input  logic [AXI_DATA_W-1:0] in_wdata,
  input  logic [3:0]            in_wstrb,
  input  logic                  in_wlast,
  output logic                  out_bvalid,
  input  logic                  in_bready,
  output logic [AXI_ID_W-1:0]   out_bid,
  output logic [1:0]            out_bresp,
  output logic [7:0]            out_err_cnt,
  output logic [15:0]           out_burst_cnt
);
  localparam int PW = $clog2(SLV_OSTD_NUM);
  logic [AXI_ID_W-1:0] aw_id [SLV_OSTD_NUM];
  logic [3:0]          aw_len [SLV_OSTD_NUM];
  logic [AXI_ID_W-1:0] b_id [SLV_OSTD_NUM];
  logic [1:0]          b_resp [SLV_OSTD_NUM];
  logic [PW-1:0]       aw_wp, aw_rp, b_wp, b_rp;
  logic                aw_full, b_full, aw_empty, b_empty;
  logic [3:0]          wcnt;
  logic                err;
  logic                aw_push, w_beat, last_hit, end_beat, id_bad, bad, b_pop;
  logic                unused_w;
  assign unused_w    = ^{in_wdata, in_wstrb};
  assign aw_empty    = (aw_wp == aw_rp) && !aw_full;
  assign b_empty     = (b_wp == b_rp) && !b_full;
  assign out_awready = aresetn && !aw_full;
  assign out_wready  = aresetn && !aw_empty && !b_full;
  assign out_bvalid  = !b_empty;
  assign out_bid     = b_id[b_rp];
  assign out_bresp   = b_resp[b_rp];
  assign aw_push     = in_awvalid && out_awready;
  assign w_beat      = in_wvalid && out_wready;
  assign last_hit    = wcnt == aw_len[aw_rp];
  assign end_beat    = w_beat && (in_wlast || last_hit);
  assign id_bad      = in_wid != aw_id[aw_rp];
  assign bad         = err || id_bad || (in_wlast != last_hit);
  assign b_pop       = out_bvalid && in_bready;
  always_ff @(posedge aclk) begin
    if (aw_push) begin
      aw_id[aw_wp]  <= in_awid;
      aw_len[aw_wp] <= in_awlen;
    end
    if (end_beat) begin
      b_id[b_wp]   <= aw_id[aw_rp];
      b_resp[b_wp] <= bad ? 2'b10 : 2'b00;
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_wp         <= '0;
      aw_rp         <= '0;
      aw_full       <= 1'b0;
      b_wp          <= '0;
      b_rp          <= '0;
      b_full        <= 1'b0;
      wcnt          <= '0;
      err           <= 1'b0;
      out_err_cnt   <= '0;
      out_burst_cnt <= '0;
    end else begin
      if (aw_push) aw_wp <= aw_wp + 1'b1;
      if (end_beat) aw_rp <= aw_rp + 1'b1;
      if (aw_push != end_beat) aw_full <= aw_push && (aw_wp + 1'b1 == aw_rp);
      if (end_beat) b_wp <= b_wp + 1'b1;
      if (b_pop) b_rp <= b_rp + 1'b1;
      if (end_beat != b_pop) b_full <= end_beat && (b_wp + 1'b1 == b_rp);
      if (w_beat) begin
        wcnt <= end_beat ? 4'd0 : wcnt + 4'd1;
        err  <= !end_beat && (err || id_bad);
      end
      if (end_beat) out_burst_cnt <= out_burst_cnt + 16'd1;
      if (end_beat && bad && out_err_cnt != 8'hFF) out_err_cnt <= out_err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_axi_slv_wsink_bresp.sv
// tb_axi_slv_wsink_bresp: directed self-checking bench for axi_slv_wsink_bresp
module tb_axi_slv_wsink_bresp;
  logic        aclk = 0, aresetn = 0;
  logic        in_awvalid = 0, out_awready;
  logic [3:0]  in_awid = 0, in_awlen = 0;
  logic        in_wvalid = 0, out_wready;
  logic [3:0]  in_wid = 0;
  logic [31:0] in_wdata = 0;
  logic [3:0]  in_wstrb = 4'hF;
  logic        in_wlast = 0;
  logic        out_bvalid, in_bready = 0;
  logic [3:0]  out_bid;
  logic [1:0]  out_bresp;
  logic [7:0]  out_err_cnt;
  logic [15:0] out_burst_cnt;
  int checks = 0, failures = 0;

  axi_slv_wsink_bresp dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_awvalid(in_awvalid), .out_awready(out_awready), .in_awid(in_awid), .in_awlen(in_awlen),
    .in_wvalid(in_wvalid), .out_wready(out_wready), .in_wid(in_wid), .in_wdata(in_wdata),
    .in_wstrb(in_wstrb), .in_wlast(in_wlast),
    .out_bvalid(out_bvalid), .in_bready(in_bready), .out_bid(out_bid), .out_bresp(out_bresp),
    .out_err_cnt(out_err_cnt), .out_burst_cnt(out_burst_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [3:0] len);
    int n = 0;
    in_awvalid = 1; in_awid = id; in_awlen = len;
    while (!out_awready && n < 50) begin step(); n++; end
    checks++;
    if (!out_awready) begin failures++; $display("FAIL aw_timeout id=%0h awready=%b want 1", id, out_awready); end
    step();
    in_awvalid = 0;
  endtask

  task automatic send_w(input logic [3:0] id, input logic last);
    int n = 0;
    in_wvalid = 1; in_wid = id; in_wlast = last; in_wdata = $urandom;
    while (!out_wready && n < 50) begin step(); n++; end
    checks++;
    if (!out_wready) begin failures++; $display("FAIL w_timeout id=%0h wready=%b want 1", id, out_wready); end
    step();
    in_wvalid = 0; in_wlast = 0;
  endtask

  task automatic test_reset();
    aresetn = 0;
    step(); step();
    checks += 2;
    if (out_awready !== 1'b0) begin failures++; $display("FAIL rst_awready got=%b want=0", out_awready); end
    if (out_wready !== 1'b0) begin failures++; $display("FAIL rst_wready got=%b want=0", out_wready); end
    aresetn = 1;
    step();
    checks += 5;
    if (out_bvalid !== 1'b0) begin failures++; $display("FAIL rst_bvalid got=%b want=0", out_bvalid); end
    if (out_awready !== 1'b1) begin failures++; $display("FAIL rst_awready_post got=%b want=1", out_awready); end
    if (out_wready !== 1'b0) begin failures++; $display("FAIL rst_wready_post got=%b want=0", out_wready); end
    if (out_burst_cnt !== 16'd0) begin failures++; $display("FAIL rst_burst_cnt got=%0d want=0", out_burst_cnt); end
    if (out_err_cnt !== 8'd0) begin failures++; $display("FAIL rst_err_cnt got=%0d want=0", out_err_cnt); end
  endtask

  task automatic test_single_burst();
    in_bready = 1;
    send_aw(4'h5, 4'd3);
    for (int i = 0; i < 4; i++) send_w(4'h5, i == 3);
    checks += 5;
    if (out_bvalid !== 1'b1) begin failures++; $display("FAIL t1_bvalid got=%b want=1", out_bvalid); end
    if (out_bid !== 4'h5) begin failures++; $display("FAIL t1_bid got=%h want=5", out_bid); end
    if (out_bresp !== 2'b00) begin failures++; $display("FAIL t1_bresp got=%b want=00", out_bresp); end
    if (out_burst_cnt !== 16'd1) begin failures++; $display("FAIL t1_burst_cnt got=%0d want=1", out_burst_cnt); end
    if (out_err_cnt !== 8'd0) begin failures++; $display("FAIL t1_err_cnt got=%0d want=0", out_err_cnt); end
    step();
    checks++;
    if (out_bvalid !== 1'b0) begin failures++; $display("FAIL t1_bpop got=%b want=0", out_bvalid); end
  endtask

  task automatic test_early_wlast();
    send_aw(4'h2, 4'd3);
    send_w(4'h2, 0);
    send_w(4'h2, 1);
    checks += 4;
    if (out_bvalid !== 1'b1) begin failures++; $display("FAIL t2_bvalid got=%b want=1", out_bvalid); end
    if (out_bid !== 4'h2) begin failures++; $display("FAIL t2_bid got=%h want=2", out_bid); end
    if (out_bresp !== 2'b10) begin failures++; $display("FAIL t2_bresp got=%b want=10", out_bresp); end
    if (out_err_cnt !== 8'd1) begin failures++; $display("FAIL t2_err_cnt got=%0d want=1", out_err_cnt); end
    step();
    send_aw(4'h2, 4'd1);
    send_w(4'h2, 0);
    send_w(4'h2, 1);
    checks += 3;
    if (out_bresp !== 2'b00) begin failures++; $display("FAIL t2_clean_bresp got=%b want=00", out_bresp); end
    if (out_err_cnt !== 8'd1) begin failures++; $display("FAIL t2_clean_err_cnt got=%0d want=1", out_err_cnt); end
    if (out_burst_cnt !== 16'd3) begin failures++; $display("FAIL t2_burst_cnt got=%0d want=3", out_burst_cnt); end
    step();
  endtask

  task automatic test_wid_mismatch();
    send_aw(4'h1, 4'd1);
    send_w(4'h1, 0);
    send_w(4'h3, 1);
    checks += 3;
    if (out_bid !== 4'h1) begin failures++; $display("FAIL t3_bid got=%h want=1", out_bid); end
    if (out_bresp !== 2'b10) begin failures++; $display("FAIL t3_bresp got=%b want=10", out_bresp); end
    if (out_err_cnt !== 8'd2) begin failures++; $display("FAIL t3_err_cnt got=%0d want=2", out_err_cnt); end
    step();
    send_aw(4'h6, 4'd0);
    send_w(4'h6, 0);
    checks += 4;
    if (out_bid !== 4'h6) begin failures++; $display("FAIL t3_nolast_bid got=%h want=6", out_bid); end
    if (out_bresp !== 2'b10) begin failures++; $display("FAIL t3_nolast_bresp got=%b want=10", out_bresp); end
    if (out_err_cnt !== 8'd3) begin failures++; $display("FAIL t3_nolast_err_cnt got=%0d want=3", out_err_cnt); end
    if (out_burst_cnt !== 16'd5) begin failures++; $display("FAIL t3_burst_cnt got=%0d want=5", out_burst_cnt); end
    step();
  endtask

  task automatic test_fill_backpressure();
    logic [3:0] ids [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    in_bready = 0;
    for (int i = 0; i < 4; i++) send_aw(ids[i], 4'd0);
    checks++;
    if (out_awready !== 1'b0) begin failures++; $display("FAIL t4_aw_full got=%b want=0", out_awready); end
    for (int i = 0; i < 4; i++) send_w(ids[i], 1);
    in_wvalid = 1; in_wid = 4'hE; in_wlast = 1;
    step(); step();
    checks += 3;
    if (out_wready !== 1'b0) begin failures++; $display("FAIL t4_wready got=%b want=0", out_wready); end
    if (out_bvalid !== 1'b1) begin failures++; $display("FAIL t4_bvalid got=%b want=1", out_bvalid); end
    if (out_bid !== 4'hA) begin failures++; $display("FAIL t4_head_hold got=%h want=a", out_bid); end
    in_wvalid = 0; in_wlast = 0;
    in_bready = 1;
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (out_bvalid !== 1'b1) begin failures++; $display("FAIL t4_drain_valid%0d got=%b want=1", i, out_bvalid); end
      if (out_bid !== ids[i] || out_bresp !== 2'b00) begin
        failures++; $display("FAIL t4_drain%0d got=%h/%b want=%h/00", i, out_bid, out_bresp, ids[i]);
      end
      step();
    end
    checks += 2;
    if (out_bvalid !== 1'b0) begin failures++; $display("FAIL t4_empty got=%b want=0", out_bvalid); end
    if (out_burst_cnt !== 16'd9) begin failures++; $display("FAIL t4_burst_cnt got=%0d want=9", out_burst_cnt); end
  endtask

  task automatic test_back_to_back();
    int a = 0, w = 0, b = 0, cyc = 0;
    logic fa, fw, fb;
    logic [3:0] ai, wi, bi;
    in_bready = 1;
    while (b < 20 && cyc < 100) begin
      ai = 4'(a); wi = 4'(w); bi = 4'(b);
      in_awvalid = a < 20; in_awid = ai; in_awlen = 0;
      in_wvalid = w < 20; in_wid = wi; in_wlast = 1;
      fa = in_awvalid && out_awready;
      fw = in_wvalid && out_wready;
      fb = out_bvalid;
      if (fb) begin
        checks++;
        if (out_bid !== bi || out_bresp !== 2'b00) begin
          failures++; $display("FAIL t5_b%0d got=%h/%b want=%h/00", b, out_bid, out_bresp, bi);
        end
      end
      step();
      a += int'(fa); w += int'(fw); b += int'(fb); cyc++;
    end
    in_awvalid = 0; in_wvalid = 0; in_wlast = 0;
    checks += 3;
    if (b != 20) begin failures++; $display("FAIL t5_count got=%0d want=20", b); end
    if (cyc != 22) begin failures++; $display("FAIL t5_cycles got=%0d want=22", cyc); end
    if (out_burst_cnt !== 16'd29) begin failures++; $display("FAIL t5_burst_cnt got=%0d want=29", out_burst_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    send_aw(4'h7, 4'd7);
    send_w(4'h7, 0);
    send_w(4'h7, 0);
    aresetn = 0;
    step();
    checks += 2;
    if (out_awready !== 1'b0) begin failures++; $display("FAIL t6_rst_awready got=%b want=0", out_awready); end
    if (out_wready !== 1'b0) begin failures++; $display("FAIL t6_rst_wready got=%b want=0", out_wready); end
    aresetn = 1;
    #1;
    checks += 5;
    if (out_bvalid !== 1'b0) begin failures++; $display("FAIL t6_bvalid got=%b want=0", out_bvalid); end
    if (out_burst_cnt !== 16'd0) begin failures++; $display("FAIL t6_burst_cnt got=%0d want=0", out_burst_cnt); end
    if (out_err_cnt !== 8'd0) begin failures++; $display("FAIL t6_err_cnt got=%0d want=0", out_err_cnt); end
    if (out_wready !== 1'b0) begin failures++; $display("FAIL t6_aw_empty got=%b want=0", out_wready); end
    if (out_awready !== 1'b1) begin failures++; $display("FAIL t6_awready got=%b want=1", out_awready); end
    step();
    send_aw(4'h9, 4'd0);
    send_w(4'h9, 1);
    checks += 4;
    if (out_bvalid !== 1'b1) begin failures++; $display("FAIL t6_new_bvalid got=%b want=1", out_bvalid); end
    if (out_bid !== 4'h9) begin failures++; $display("FAIL t6_new_bid got=%h want=9", out_bid); end
    if (out_bresp !== 2'b00) begin failures++; $display("FAIL t6_new_bresp got=%b want=00", out_bresp); end
    if (out_burst_cnt !== 16'd1) begin failures++; $display("FAIL t6_new_burst_cnt got=%0d want=1", out_burst_cnt); end
    step();
  endtask

  initial begin
    step();
    test_reset();
    test_single_burst();
    test_early_wlast();
    test_wid_mismatch();
    test_fill_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
